// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises IFU fetches and LSU loads/stores onto one synchronous RAM port.
// Build option MEM_ARB_RR_EN: simultaneous requests alternate owners instead of fixed LSU priority.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_done,
    output logic [DATA_W-1:0]   ifu_rdata,
    input  logic                lsu_req,
    input  logic                lsu_we,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_done,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                ram_en,
    output logic [DATA_W/8-1:0] ram_we,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    input  logic [DATA_W-1:0]   ram_rdata,
    output logic                busy
);

    // state | meaning
    // IDLE  | no access; grant on any request
    // ISSUE | ram_en high for this one cycle
    // WAIT  | counting down the RAM read latency
    // RESP  | owner's done pulse; requests ignored
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic       OWN_IFU = 1'b0;
    localparam logic       OWN_LSU = 1'b1;
    localparam logic [2:0] LAT     = 3'(RD_LAT);

    state_t              state, state_next;
    logic [2:0]          cnt, cnt_next;
    logic                owner, owner_next;
    logic                store, store_next;
    logic                tie_to_lsu;
    logic                ram_en_next, busy_next;
    logic                ifu_done_next, lsu_done_next;
    logic [DATA_W/8-1:0] ram_we_next;
    logic [ADDR_W-1:0]   ram_addr_next;
    logic [DATA_W-1:0]   ram_wdata_next, ifu_rdata_next, lsu_rdata_next;

`ifdef MEM_ARB_RR_EN
    // owner only changes at grant, so it doubles as the last-owner record
    assign tie_to_lsu = (owner == OWN_IFU);
`else
    assign tie_to_lsu = 1'b1;
`endif

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        owner_next     = owner;
        store_next     = store;
        ram_en_next    = 1'b0;
        ram_we_next    = ram_we;
        ram_addr_next  = ram_addr;
        ram_wdata_next = ram_wdata;
        ifu_done_next  = 1'b0;
        lsu_done_next  = 1'b0;
        ifu_rdata_next = ifu_rdata;
        lsu_rdata_next = lsu_rdata;
        case (state)
            IDLE: begin
                if (ifu_req || lsu_req) begin
                    state_next  = ISSUE;
                    ram_en_next = 1'b1;
                    if (lsu_req && (!ifu_req || tie_to_lsu)) begin
                        owner_next     = OWN_LSU;
                        store_next     = lsu_we;
                        ram_addr_next  = lsu_addr;
                        ram_wdata_next = lsu_wdata;
                        ram_we_next    = lsu_we ? lsu_wmask : '0;
                    end else begin
                        owner_next    = OWN_IFU;
                        store_next    = 1'b0;
                        ram_addr_next = ifu_addr;
                        ram_we_next   = '0;
                    end
                end
            end
            ISSUE: begin
                cnt_next    = LAT;
                ram_we_next = '0;
                state_next  = WAIT;
            end
            WAIT: begin
                if (cnt == 3'd1) begin
                    cnt_next   = '0;
                    state_next = RESP;
                    if (owner == OWN_LSU) begin
                        lsu_done_next = 1'b1;
                        if (!store) lsu_rdata_next = ram_rdata;
                    end else begin
                        ifu_done_next  = 1'b1;
                        ifu_rdata_next = ram_rdata;
                    end
                end else begin
                    cnt_next = cnt - 3'd1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            owner     <= OWN_IFU;
            store     <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ifu_done  <= 1'b0;
            lsu_done  <= 1'b0;
            ifu_rdata <= '0;
            lsu_rdata <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            owner     <= owner_next;
            store     <= store_next;
            ram_en    <= ram_en_next;
            ram_we    <= ram_we_next;
            ram_addr  <= ram_addr_next;
            ram_wdata <= ram_wdata_next;
            ifu_done  <= ifu_done_next;
            lsu_done  <= lsu_done_next;
            ifu_rdata <= ifu_rdata_next;
            lsu_rdata <= lsu_rdata_next;
            busy      <= busy_next;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus randomized accesses against a behavioural model.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // instance with RD_LAT=1
    logic        ifu_req, lsu_req, lsu_we, ifu_done, lsu_done, ram_en, busy;
    logic [31:0] ifu_addr, lsu_addr, lsu_wdata, ifu_rdata, lsu_rdata;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic [3:0]  lsu_wmask, ram_we;

    // instance with RD_LAT=3
    logic        b_ifu_req, b_lsu_req, b_lsu_we, b_ifu_done, b_lsu_done, b_ram_en, b_busy;
    logic [31:0] b_ifu_addr, b_lsu_addr, b_lsu_wdata, b_ifu_rdata, b_lsu_rdata;
    logic [31:0] b_ram_addr, b_ram_wdata, b_ram_rdata;
    logic [3:0]  b_lsu_wmask, b_ram_we;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_done(ifu_done), .ifu_rdata(ifu_rdata),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_wmask(lsu_wmask), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .busy(busy)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .ifu_req(b_ifu_req), .ifu_addr(b_ifu_addr), .ifu_done(b_ifu_done), .ifu_rdata(b_ifu_rdata),
        .lsu_req(b_lsu_req), .lsu_we(b_lsu_we), .lsu_addr(b_lsu_addr), .lsu_wdata(b_lsu_wdata),
        .lsu_wmask(b_lsu_wmask), .lsu_done(b_lsu_done), .lsu_rdata(b_lsu_rdata),
        .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata),
        .ram_rdata(b_ram_rdata), .busy(b_busy)
    );

    // RAM models: 16 words indexed by addr[5:2], backdoor preload writes both
    logic        pre_we = 1'b0;
    logic [3:0]  pre_idx;
    logic [31:0] pre_data;
    logic [31:0] mem1 [16];
    logic [31:0] mem3 [16];
    logic [31:0] p3 [3];

    always @(posedge clk) begin
        if (pre_we) begin
            mem1[pre_idx] <= pre_data;
            mem3[pre_idx] <= pre_data;
        end
        if (ram_en)
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem1[ram_addr[5:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
        ram_rdata <= ram_en ? mem1[ram_addr[5:2]] : $urandom;
        p3[0] <= b_ram_en ? mem3[b_ram_addr[5:2]] : $urandom;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign b_ram_rdata = p3[2];

    // behavioural model state
    int          checks = 0;
    int          errors = 0;
    logic [31:0] shadow [16];
    logic        last_own;     // 0 = IFU, 1 = LSU
    logic [31:0] exp_ifu, exp_lsu;

    function automatic logic tie_winner(input logic last);
`ifdef MEM_ARB_RR_EN
        return ~last;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic preload_word(input int idx, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_idx = 4'(idx); pre_data = d;
        shadow[idx] = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ifu_req = 0; lsu_req = 0; lsu_we = 0; ifu_addr = 0; lsu_addr = 0; lsu_wdata = 0; lsu_wmask = 0;
        b_ifu_req = 0; b_lsu_req = 0; b_lsu_we = 0; b_ifu_addr = 0; b_lsu_addr = 0;
        b_lsu_wdata = 0; b_lsu_wmask = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        last_own = 1'b0; exp_ifu = '0; exp_lsu = '0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({ram_en, ram_we, ram_addr, ram_wdata, ifu_done, lsu_done, ifu_rdata, lsu_rdata, busy} !== '0) begin
            errors++; $display("FAIL reset_outputs got en=%b we=%h addr=%h busy=%b expected all zero", ram_en, ram_we, ram_addr, busy);
        end
        checks++;
        if ({b_ram_en, b_ram_we, b_ram_addr, b_ram_wdata, b_ifu_done, b_lsu_done, b_ifu_rdata, b_lsu_rdata, b_busy} !== '0) begin
            errors++; $display("FAIL reset_outputs_lat3 got en=%b busy=%b expected all zero", b_ram_en, b_busy);
        end
        for (int i = 0; i < 16; i++) preload_word(i, $urandom);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (ram_en !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL idle_quiet got en=%b busy=%b expected 0 0", ram_en, busy);
            end
        end
    endtask

    task automatic test_ifu_read();
        preload_word(4, 32'h0050_0093);
        ifu_addr = 32'h10; ifu_req = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++;
            if (ram_en !== (k == 1)) begin
                errors++; $display("FAIL ifu_ram_en k=%0d got %b expected %b", k, ram_en, k == 1);
            end
            if (k == 1) begin
                checks++;
                if (ram_addr !== 32'h10 || ram_we !== 4'h0 || busy !== 1'b1) begin
                    errors++; $display("FAIL ifu_issue got addr=%h we=%h busy=%b expected 10 0 1", ram_addr, ram_we, busy);
                end
            end
            checks++;
            if ({ifu_done, lsu_done} !== {k == 3, 1'b0}) begin
                errors++; $display("FAIL ifu_done k=%0d got %b%b expected %b0", k, ifu_done, lsu_done, k == 3);
            end
            if (k >= 3) begin
                checks++;
                if (ifu_rdata !== 32'h0050_0093) begin
                    errors++; $display("FAIL ifu_rdata k=%0d got %h expected 00500093", k, ifu_rdata);
                end
            end
            if (k == 3) ifu_req = 1'b0;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL ifu_busy_end got %b expected 0", busy);
        end
        exp_ifu = 32'h0050_0093; last_own = 1'b0;
    endtask

    task automatic test_lat3();
        b_lsu_addr = 32'h28; b_lsu_we = 1'b0; b_lsu_req = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            checks++;
            if (b_busy !== ((k <= 5) || (k >= 7 && k <= 11))) begin
                errors++; $display("FAIL lat3_busy k=%0d got %b", k, b_busy);
            end
            checks++;
            if ({b_lsu_done, b_ifu_done, b_ram_en} !== {k == 5, k == 11, (k == 1) || (k == 7)}) begin
                errors++; $display("FAIL lat3_timing k=%0d got lsu_done=%b ifu_done=%b en=%b", k, b_lsu_done, b_ifu_done, b_ram_en);
            end
            if (k == 2) begin b_ifu_addr = 32'h2C; b_ifu_req = 1'b1; end
            if (k == 5) begin
                checks++;
                if (b_lsu_rdata !== shadow[10]) begin
                    errors++; $display("FAIL lat3_lsu_rdata got %h expected %h", b_lsu_rdata, shadow[10]);
                end
                b_lsu_req = 1'b0;
            end
            if (k == 7) begin
                checks++;
                if (b_ram_addr !== 32'h2C) begin
                    errors++; $display("FAIL lat3_ifu_addr got %h expected 2c", b_ram_addr);
                end
            end
            if (k == 11) begin
                checks++;
                if (b_ifu_rdata !== shadow[11]) begin
                    errors++; $display("FAIL lat3_ifu_rdata got %h expected %h", b_ifu_rdata, shadow[11]);
                end
                b_ifu_req = 1'b0;
            end
        end
    endtask

    task automatic test_lsu_store();
        logic [31:0] exp_tbl [3];
        exp_tbl = '{32'h1122_3344, 32'h1122_3344, 32'h1122_33DD};
        preload_word(1, 32'h1122_3344);
        for (int op = 0; op < 3; op++) begin
            lsu_we = (op == 1); lsu_addr = 32'h104; lsu_wdata = 32'hAABB_CCDD;
            lsu_wmask = 4'b0001; lsu_req = 1'b1;
            for (int k = 1; k <= 3; k++) begin
                @(negedge clk);
                if (k == 1) begin
                    checks++;
                    if (ram_en !== 1'b1 || ram_addr !== 32'h104 || ram_we !== ((op == 1) ? 4'b0001 : 4'b0000)) begin
                        errors++; $display("FAIL store_issue op=%0d got en=%b addr=%h we=%b", op, ram_en, ram_addr, ram_we);
                    end
                    if (op == 1) begin
                        checks++;
                        if (ram_wdata !== 32'hAABB_CCDD) begin
                            errors++; $display("FAIL store_wdata got %h expected aabbccdd", ram_wdata);
                        end
                    end
                end
                checks++;
                if (lsu_done !== (k == 3)) begin
                    errors++; $display("FAIL store_done op=%0d k=%0d got %b", op, k, lsu_done);
                end
            end
            checks++;
            if (lsu_rdata !== exp_tbl[op]) begin
                errors++; $display("FAIL store_lsu_rdata op=%0d got %h expected %h", op, lsu_rdata, exp_tbl[op]);
            end
            lsu_req = 1'b0;
            @(negedge clk);
        end
        shadow[1] = 32'h1122_33DD; exp_lsu = 32'h1122_33DD; last_own = 1'b1;
    endtask

    task automatic test_tie();
        int   ndone, cyc;
        logic exp_w, got_w;
        ndone = 0; cyc = 0;
        ifu_addr = 32'h20; lsu_addr = 32'h24; lsu_we = 1'b0;
        ifu_req = 1'b1; lsu_req = 1'b1;
        while (ndone < 3 && cyc < 30) begin
            @(negedge clk);
            cyc++;
            checks++;
            if (ifu_done && lsu_done) begin
                errors++; $display("FAIL tie_both_done cyc=%0d got 11 expected at most one", cyc);
            end
            if (ifu_done || lsu_done) begin
                got_w = lsu_done;
                exp_w = tie_winner(last_own);
                last_own = exp_w;
                checks++;
                if (got_w !== exp_w || cyc != 3 + 4 * ndone) begin
                    errors++; $display("FAIL tie_order n=%0d got owner=%b cyc=%0d expected owner=%b cyc=%0d", ndone, got_w, cyc, exp_w, 3 + 4 * ndone);
                end
                if (got_w) exp_lsu = shadow[lsu_addr[5:2]];
                else       exp_ifu = shadow[ifu_addr[5:2]];
                checks++;
                if (ifu_rdata !== exp_ifu || lsu_rdata !== exp_lsu) begin
                    errors++; $display("FAIL tie_rdata got %h %h expected %h %h", ifu_rdata, lsu_rdata, exp_ifu, exp_lsu);
                end
                ndone++;
                if (ndone == 3) begin
                    ifu_req = 1'b0; lsu_req = 1'b0;
                end else if (got_w) lsu_addr = lsu_addr + 32'h8;
                else                ifu_addr = ifu_addr + 32'h8;
            end
        end
        checks++;
        if (ndone != 3) begin
            errors++; $display("FAIL tie_timeout got %0d dones expected 3", ndone);
            ifu_req = 1'b0; lsu_req = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_late_change();
        preload_word(13, ~shadow[12]);
        lsu_we = 1'b0; lsu_addr = 32'h30; lsu_req = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k <= 2) begin
                checks++;
                if (ram_addr !== 32'h30) begin
                    errors++; $display("FAIL late_addr k=%0d got %h expected 30", k, ram_addr);
                end
            end
            if (k == 1) lsu_addr = 32'h34;
        end
        checks++;
        if (lsu_done !== 1'b1 || lsu_rdata !== shadow[12]) begin
            errors++; $display("FAIL late_rdata got done=%b data=%h expected 1 %h", lsu_done, lsu_rdata, shadow[12]);
        end
        exp_lsu = shadow[12]; last_own = 1'b1;
        lsu_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        ifu_addr = 32'h38; ifu_req = 1'b1;
        @(negedge clk);
        checks++;
        if (ram_en !== 1'b1) begin
            errors++; $display("FAIL mid_issue got en=%b expected 1", ram_en);
        end
        @(negedge clk);
        rst = 1'b1; ifu_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({ram_en, ram_we, ram_addr, ram_wdata, ifu_done, lsu_done, ifu_rdata, lsu_rdata, busy} !== '0) begin
            errors++; $display("FAIL mid_reset_outputs got addr=%h ifu_rdata=%h lsu_rdata=%h busy=%b expected zero", ram_addr, ifu_rdata, lsu_rdata, busy);
        end
        rst = 1'b0;
        last_own = 1'b0; exp_ifu = '0; exp_lsu = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (ifu_done !== 1'b0 || lsu_done !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL mid_no_done got %b%b busy=%b expected 00 0", ifu_done, lsu_done, busy);
            end
        end
        ifu_addr = 32'h3C; ifu_req = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (ifu_done !== (k == 3)) begin
                errors++; $display("FAIL mid_after_done k=%0d got %b", k, ifu_done);
            end
        end
        checks++;
        if (ifu_rdata !== shadow[15]) begin
            errors++; $display("FAIL mid_after_rdata got %h expected %h", ifu_rdata, shadow[15]);
        end
        exp_ifu = shadow[15];
        ifu_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        int          mode, n, w;
        logic        ord [2];
        logic        own;
        logic [31:0] ea;
        logic [3:0]  ew;
        for (int it = 0; it < 60; it++) begin
            mode = $urandom_range(0, 2);
            ifu_addr = $urandom; lsu_addr = $urandom; lsu_wdata = $urandom;
            lsu_we = 1'($urandom_range(0, 1)); lsu_wmask = 4'($urandom_range(0, 15));
            ifu_req = (mode != 1); lsu_req = (mode != 0);
            if (mode == 2) begin
                ord[0] = tie_winner(last_own); ord[1] = ~ord[0]; n = 2;
            end else begin
                ord[0] = (mode == 1); ord[1] = 1'b0; n = 1;
            end
            for (int a = 0; a < n; a++) begin
                own = ord[a];
                w = 0;
                do begin
                    @(negedge clk); w++;
                end while (ram_en !== 1'b1 && w < 8);
                checks++;
                if (w != ((a == 0) ? 1 : 2)) begin
                    errors++; $display("FAIL rnd_grant_latency it=%0d got %0d expected %0d", it, w, (a == 0) ? 1 : 2);
                end
                last_own = own;
                ea = own ? lsu_addr : ifu_addr;
                ew = (own && lsu_we) ? lsu_wmask : 4'h0;
                checks++;
                if (ram_addr !== ea || ram_we !== ew || (ew != 0 && ram_wdata !== lsu_wdata)) begin
                    errors++; $display("FAIL rnd_issue it=%0d got addr=%h we=%h wd=%h expected %h %h %h", it, ram_addr, ram_we, ram_wdata, ea, ew, lsu_wdata);
                end
                for (int j = 1; j <= 2; j++) begin
                    @(negedge clk);
                    checks++;
                    if ({ifu_done, lsu_done} !== ((j == 2) ? {~own, own} : 2'b00)) begin
                        errors++; $display("FAIL rnd_done it=%0d j=%0d got %b%b owner=%b", it, j, ifu_done, lsu_done, own);
                    end
                end
                if (!own) exp_ifu = shadow[ea[5:2]];
                else if (!lsu_we) exp_lsu = shadow[ea[5:2]];
                else shadow[ea[5:2]] = merge(shadow[ea[5:2]], lsu_wdata, lsu_wmask);
                checks++;
                if (ifu_rdata !== exp_ifu || lsu_rdata !== exp_lsu) begin
                    errors++; $display("FAIL rnd_rdata it=%0d got %h %h expected %h %h", it, ifu_rdata, lsu_rdata, exp_ifu, exp_lsu);
                end
                if (own) lsu_req = 1'b0;
                else     ifu_req = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        rst = 1'b1;
        test_reset();
        test_ifu_read();
        test_lat3();
        test_lsu_store();
        test_tie();
        test_late_change();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
